// File: rtl/mips_reg_write_arbiter.sv
// Two-slot writeback arbiter in front of the MIPS register file write port.
// Optional macro REGARB_ZERO_FILTER_EN drops writes to register 0 at the slot.
module mips_reg_write_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        signal_reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [31:0] pending_mask
);

  typedef struct packed {
    logic        full;
    logic [4:0]  rd;
    logic [31:0] data;
  } slot_t;

  slot_t a_q, a_d, b_q, b_d;
  logic  a_old_q, a_old_d;   // set: A is the older slot when both are full
  logic  gnt_a, gnt_b, xfer_a, xfer_b, keep_a, keep_b, fill_a, fill_b;

  assign gnt_a   = a_q.full && (!b_q.full || a_old_q);
  assign gnt_b   = b_q.full && (!a_q.full || !a_old_q);
  assign a_ready = !a_q.full || gnt_a;
  assign b_ready = !b_q.full || gnt_b;
  assign xfer_a  = a_valid && a_ready;
  assign xfer_b  = b_valid && b_ready;

`ifdef REGARB_ZERO_FILTER_EN
  assign keep_a = (a_reg != 5'd0);
  assign keep_b = (b_reg != 5'd0);
`else
  assign keep_a = 1'b1;
  assign keep_b = 1'b1;
`endif

  assign fill_a = xfer_a && keep_a;
  assign fill_b = xfer_b && keep_b;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    a_old_d = a_old_q;
    if (gnt_a) a_d.full = 1'b0;
    if (gnt_b) b_d.full = 1'b0;
    if (xfer_a) a_d = '{full: keep_a, rd: a_reg, data: a_data};
    if (xfer_b) b_d = '{full: keep_b, rd: b_reg, data: b_data};
    // A newly filled slot is younger than whatever stays queued; a tie goes to A.
    if (fill_a && fill_b) a_old_d = 1'b1;
    else if (fill_a)      a_old_d = 1'b0;
    else if (fill_b)      a_old_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      a_old_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_old_q <= a_old_d;
    end
  end

  always_comb begin
    signal_reg_write = 1'b0;
    write_reg        = 5'd0;
    write_data       = 32'd0;
    if (gnt_a) begin
      signal_reg_write = 1'b1;
      write_reg        = a_q.rd;
      write_data       = a_q.data;
    end else if (gnt_b) begin
      signal_reg_write = 1'b1;
      write_reg        = b_q.rd;
      write_data       = b_q.data;
    end
  end

  always_comb begin
    pending_mask = 32'd0;
    if (a_q.full) pending_mask[a_q.rd] = 1'b1;
    if (b_q.full) pending_mask[b_q.rd] = 1'b1;
  end

endmodule

// File: tb/tb_mips_reg_write_arbiter.sv
// Randomized bench: the reference is an age-ordered queue of accepted writes.
module tb_mips_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg = '0, b_reg = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        signal_reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending_mask;

  mips_reg_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .signal_reg_write(signal_reg_write), .write_reg(write_reg),
    .write_data(write_data), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

`ifdef REGARB_ZERO_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  typedef struct packed {
    logic        src;   // 0 = A, 1 = B
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] rf_exp [32];
  logic [31:0] rf_dut [32];
  int          nwr = 0;
  int          compared = 0;
  int          mismatched = 0;

  wire [71:0] obs = {signal_reg_write, write_reg, write_data, a_ready, b_ready, pending_mask};

  always @(posedge clk) if (signal_reg_write) begin
    rf_dut[write_reg] <= write_data;
    nwr <= nwr + 1;
  end

  function automatic logic m_ready(input logic src);
    for (int i = 0; i < q.size(); i++)
      if (q[i].src == src) return (i == 0);
    return 1'b1;
  endfunction

  function automatic logic [71:0] exp_vec();
    logic [31:0] m;
    m = 32'd0;
    foreach (q[i]) m = m | (32'd1 << q[i].r);
    if (q.size() == 0) return {1'b0, 5'd0, 32'd0, m_ready(1'b0), m_ready(1'b1), m};
    return {1'b1, q[0].r, q[0].d, m_ready(1'b0), m_ready(1'b1), m};
  endfunction

  // Advance one clock: oldest queued write retires, then A and B enqueue in that order.
  task automatic tick();
    logic ra, rb;
    ra = m_ready(1'b0);
    rb = m_ready(1'b1);
    @(posedge clk);
    if (q.size() != 0) begin
      rf_exp[q[0].r] = q[0].d;
      void'(q.pop_front());
    end
    if (a_valid && ra && !(ZF && a_reg == 5'd0)) q.push_back('{1'b0, a_reg, a_data});
    if (b_valid && rb && !(ZF && b_reg == 5'd0)) q.push_back('{1'b1, b_reg, b_data});
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    q.delete();
    #1;
    compared++;
    if (obs !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0}) begin
      mismatched++;
      $display("FAIL reset_in got %h required %h", obs, {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (obs !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0}) begin
        mismatched++;
        $display("FAIL reset_idle got %h required %h", obs, {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0});
      end
      tick();
    end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h0000_1234;
    tick();
    idle_inputs();
    compared++;
    if ({signal_reg_write, write_reg, write_data, pending_mask} !== {1'b1, 5'd5, 32'h1234, 32'h20}) begin
      mismatched++;
      $display("FAIL single_issue got %h required %h",
               {signal_reg_write, write_reg, write_data, pending_mask}, {1'b1, 5'd5, 32'h1234, 32'h20});
    end
    tick();
    compared++;
    if (rf_dut[5] !== 32'h1234 || signal_reg_write !== 1'b0) begin
      mismatched++;
      $display("FAIL single_rf got r5=%h we=%b required r5=00001234 we=0", rf_dut[5], signal_reg_write);
    end
  endtask

  task automatic test_same_reg();
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h22;
    tick();
    idle_inputs();
    compared++;
    if ({signal_reg_write, write_reg, write_data, a_ready, b_ready} !== {1'b1, 5'd3, 32'h11, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL same_reg_first got %h required %h",
               {signal_reg_write, write_reg, write_data, a_ready, b_ready}, {1'b1, 5'd3, 32'h11, 1'b1, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL same_reg_cyc%0d got %h required %h", i, obs, exp_vec());
      end
      tick();
    end
    compared++;
    if (rf_dut[3] !== 32'h22) begin
      mismatched++;
      $display("FAIL same_reg_rf got %h required 00000022", rf_dut[3]);
    end
  endtask

  task automatic test_back_to_back();
    int ai = 0, bi = 0, n0, guard = 0;
    logic ra, rb;
    n0 = nwr;
    while ((ai < 4 || bi < 4) && guard < 40) begin
      a_valid = (ai < 4); a_reg = 5'(1 + ai); a_data = 32'hA000_0000 + 32'(ai);
      b_valid = (bi < 4); b_reg = 5'(8 + bi); b_data = 32'hB000_0000 + 32'(bi);
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL stream_cyc%0d got %h required %h", guard, obs, exp_vec());
      end
      ra = m_ready(1'b0);
      rb = m_ready(1'b1);
      tick();
      if (a_valid && ra) ai++;
      if (b_valid && rb) bi++;
      guard++;
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL stream_drain%0d got %h required %h", i, obs, exp_vec());
      end
      tick();
    end
    compared++;
    if (nwr - n0 !== 8 || guard >= 40) begin
      mismatched++;
      $display("FAIL stream_count got %0d writes (guard %0d) required 8", nwr - n0, guard);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      a_valid = 1'($urandom_range(0, 1)); a_reg = 5'($urandom_range(0, 31)); a_data = $urandom;
      b_valid = 1'($urandom_range(0, 1)); b_reg = 5'($urandom_range(0, 31)); b_data = $urandom;
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL random_cyc%0d got %h required %h", i, obs, exp_vec());
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int n0;
    a_valid = 1'b1; a_reg = 5'd20; a_data = 32'hDEAD_0001;
    b_valid = 1'b1; b_reg = 5'd21; b_data = 32'hDEAD_0002;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    q.delete();
    #1;
    n0 = nwr;
    compared++;
    if (obs !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0}) begin
      mismatched++;
      $display("FAIL reset_mid got %h required %h", obs, {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd0});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL reset_after%0d got %h required %h", i, obs, exp_vec());
      end
      tick();
    end
    compared++;
    if (nwr !== n0) begin
      mismatched++;
      $display("FAIL reset_nowrite got %0d writes required 0", nwr - n0);
    end
  endtask

  task automatic test_zero_reg();
    int n0;
    n0 = nwr;
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF;
    compared++;
    if (b_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_ready got %b required 1", b_ready);
    end
    tick();
    idle_inputs();
    compared++;
    if ({signal_reg_write, pending_mask} !== (ZF ? 33'd0 : {1'b1, 32'd1})) begin
      mismatched++;
      $display("FAIL zero_issue got %h required %h",
               {signal_reg_write, pending_mask}, (ZF ? 33'd0 : {1'b1, 32'd1}));
    end
    repeat (2) tick();
    compared++;
    if (nwr - n0 !== (ZF ? 0 : 1)) begin
      mismatched++;
      $display("FAIL zero_count got %0d required %0d", nwr - n0, ZF ? 0 : 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_exp[i] = 32'd0;
      rf_dut[i] = 32'd0;
    end
    test_reset();
    test_single();
    test_same_reg();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_zero_reg();
    for (int i = 0; i < 32; i++) begin
      compared++;
      if (rf_dut[i] !== rf_exp[i]) begin
        mismatched++;
        $display("FAIL regfile_r%0d got %h required %h", i, rf_dut[i], rf_exp[i]);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_reg_write_arbiter.md
# mips_reg_write_arbiter

Shares the single write port of the 32×32 MIPS register file between two writeback requesters: A (ALU/R-type) and B (load/memory). Each requester has a one-entry holding slot with valid/ready handshake. The block selects one slot per cycle in age order and drives the register file's `signal_reg_write`/`write_reg`/`write_data` inputs. It also exports a pending-write mask for hazard detection in the decode stage.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- clk  in  1  rising-edge clock shared with the register file
- rst_n  in  1  reset, asynchronous, active-low
- a_valid  in  1  requester A offers a write
- a_ready  out  1  slot A can accept this cycle
- a_reg  in  5  destination register, A
- a_data  in  32  write data, A
- b_valid, b_ready, b_reg, b_data: same as A, for requester B
- signal_reg_write  out  1  write enable to register file
- write_reg  out  5  register file write index
- write_data  out  32  register file write data
- pending_mask  out  32  bit r set while any full slot targets register r

## Operation
- Per-slot state: EMPTY or FULL, holding reg, data and a 1-bit age flag.
- Handshake: transfer on X_valid && X_ready at the rising edge. X_ready = slot EMPTY, or slot FULL and granted this cycle. This allows back-to-back transfers at one per cycle from each side.
- Grant (combinational, from slot state only):
  - Only one slot FULL: grant it.
  - Both FULL: grant the older slot.
  - Both filled on the same edge: A is older.
- Age rule: on fill, the slot is younger than the other FULL slot, if any.
- Granted slot drives write_reg/write_data with signal_reg_write=1. At the next edge the granted slot becomes EMPTY, or is refilled if its requester transfers on that edge.
- No grant: signal_reg_write=0, write_reg=0, write_data=0.
- Same register in both slots: the older write is performed first and the younger second, so the last accepted value persists.
- pending_mask is the OR of one-hot(reg) over FULL slots, combinational from state.
- Requester inputs are sampled only on a transfer; they are don't-care otherwise.

## Timing
- Reset (async assert, sync release on clk):
  - Both slots EMPTY, age cleared.
  - signal_reg_write=0, write_reg=0, write_data=0, pending_mask=0.
  - a_ready=b_ready=1.
- Latency, uncontended: transfer at edge N → signal_reg_write high in cycle N..N+1 → register file updated at edge N+1.
- Contended: the younger slot writes one cycle later, so its write lands at edge N+2. Its ready is low for that cycle.
- Sustained throughput: one register-file write per cycle. If both requesters issue every cycle, each sees ready low on alternate cycles.
- Reset asserted mid-operation: queued writes are discarded and no partial write is issued.

## Configuration
- REGARB_ZERO_FILTER_EN defined:
  - A transfer with reg=0 is accepted (ready per normal rules) but the slot stays EMPTY.
  - No write is ever issued to register 0, and pending_mask[0] stays 0.
- Not defined: register 0 writes are queued and issued like any other.

## Test plan
- Reset, then idle → all outputs 0, a_ready=b_ready=1, pending_mask=0.
- A writes r5=0x0000_1234 alone → next cycle signal_reg_write=1, write_reg=5, write_data=0x1234, pending_mask=0x20. The register file reads 0x1234 after the following edge.
- A (r3=0x11) and B (r3=0x22) transfer on the same edge → A is issued first, then B, with b_ready=0 for one cycle. Register 3 ends at 0x22.
- A streams r1..r4 while B streams r8..r11, both valid every cycle → 8 writes in 8 consecutive cycles, alternating by age, with no loss and no duplicates.
- rst_n pulsed low while both slots are FULL → outputs go to 0 immediately, and no write is issued after release.
- With REGARB_ZERO_FILTER_EN: B writes r0=0xFFFF_FFFF → accepted, signal_reg_write stays 0, pending_mask=0. Without the macro: one write to r0 is issued.
